anita3_event_writer: RTL and testbench

Upstream fill stage for the two-buffer event RAM in the 33 MHz domain. Accepts one event descriptor plus a 16-bit payload stream. Formats each event into a fixed 64-word record (header, payload, padding, length, checksum) and writes it into the next free buffer through the RAM write port (addr[7:6] = buffer, addr[5:0] = word). Frees buffers in order on the consumer's clear pulse; drops and counts events when both buffers are occupied.

---
 rtl/anita3_evw_pkg.sv | 29 ++
 rtl/anita3_evbuf_tracker.sv | 43 ++++
 rtl/anita3_event_writer.sv | 219 +++++++++++++++++++++
 tb/tb_anita3_event_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_evw_pkg.sv
// Shared constants, record word map and FSM state type for the ANITA-3 event writer.
package anita3_evw_pkg;

    localparam int NUM_BUFFERS     = 2;
    localparam int WORDS_PER_EVENT = 64;
    localparam int HDR_WORDS       = 6;

    localparam logic [15:0] EVT_MAGIC     = 16'hA3E7;
    localparam logic [5:0]  PAYLOAD_FIRST = 6'(HDR_WORDS);
    localparam logic [5:0]  PAYLOAD_LAST  = 6'(WORDS_PER_EVENT - 3);
    localparam logic [5:0]  LEN_WORD      = 6'(WORDS_PER_EVENT - 2);
    localparam logic [5:0]  TRAILER_WORD  = 6'(WORDS_PER_EVENT - 1);
    localparam logic [1:0]  BUF_LIMIT     = 2'(NUM_BUFFERS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DISCARD,
        PAD,
        DONE,
        DROP
    } evw_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/anita3_evbuf_tracker.sv
// Buffer occupancy tracker: write pointer, full count, and done/clear arbitration.
module anita3_evbuf_tracker
    import anita3_evw_pkg::*;
(
    input  logic       clk33_i,
    input  logic       rst_n_i,
    input  logic       done_i,
    input  logic       clear_i,
    output logic [1:0] wr_ptr_o,
    output logic [1:0] full_count_o
);

    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] full_reg, full_next;

    always_comb begin
        ptr_next  = ptr_reg;
        full_next = full_reg;
        if (done_i) begin
            ptr_next = (ptr_reg == BUF_LIMIT - 2'd1) ? 2'd0 : ptr_reg + 2'd1;
        end
        // A clear landing on the done cycle cancels the increment.
        if (done_i && !clear_i) begin
            full_next = full_reg + 2'd1;
        end else if (!done_i && clear_i && full_reg != 2'd0) begin
            full_next = full_reg - 2'd1;
        end
    end

    always_ff @(posedge clk33_i) begin
        if (!rst_n_i) begin
            ptr_reg  <= 2'd0;
            full_reg <= 2'd0;
        end else begin
            ptr_reg  <= ptr_next;
            full_reg <= full_next;
        end
    end

    assign wr_ptr_o     = ptr_reg;
    assign full_count_o = full_reg;

endmodule

// File: rtl/anita3_event_writer.sv
// Formats one event into a 64-word record and writes it into the next free buffer.
// Optional EVENT_WRITER_CHECKSUM_EN: trailer word carries the 16-bit sum of words 0..62.
module anita3_event_writer
    import anita3_evw_pkg::*;
(
    input  logic        clk33_i,
    input  logic        rst_n_i,
    input  logic        evt_valid_i,
    output logic        evt_ready_o,
    input  logic [31:0] evt_number_i,
    input  logic [31:0] evt_time_i,
    input  logic [15:0] evt_pattern_i,
    input  logic [15:0] pay_dat_i,
    input  logic        pay_valid_i,
    input  logic        pay_last_i,
    output logic        pay_ready_o,
    input  logic        clear_evt_i,
    output logic [7:0]  event_wr_addr_o,
    output logic [15:0] event_wr_dat_o,
    output logic        event_wr_o,
    output logic        event_done_o,
    output logic [1:0]  full_count_o,
    output logic [15:0] dropped_count_o,
    output logic        busy_o
);

    evw_state_t  state_reg, state_next;
    logic [5:0]  idx_reg, idx_next;
    logic [7:0]  count_reg, count_next;
    logic        trunc_reg, trunc_next;
    logic [1:0]  bufid_reg, bufid_next;
    logic [31:0] num_reg, time_reg;
    logic [15:0] pat_reg;

    logic        evt_ready_reg, pay_ready_reg, wr_reg, done_reg, busy_reg;
    logic [7:0]  addr_reg;
    logic [15:0] dat_reg, dropped_reg;

    logic        wr_next, done_next, latch_desc, drop_evt, pay_accept;
    logic [5:0]  word_next;
    logic [15:0] dat_next, hdr_word, trailer_word;
    logic [1:0]  wr_ptr, full_count;

    anita3_evbuf_tracker u_tracker (
        .clk33_i      (clk33_i),
        .rst_n_i      (rst_n_i),
        .done_i       (done_reg),
        .clear_i      (clear_evt_i),
        .wr_ptr_o     (wr_ptr),
        .full_count_o (full_count)
    );

    assign pay_accept = pay_valid_i && pay_ready_reg;

    always_comb begin
        hdr_word = 16'h0000;
        case (idx_reg)
            6'd1:    hdr_word = num_reg[31:16];
            6'd2:    hdr_word = num_reg[15:0];
            6'd3:    hdr_word = time_reg[31:16];
            6'd4:    hdr_word = time_reg[15:0];
            6'd5:    hdr_word = pat_reg;
            default: hdr_word = 16'h0000;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        trunc_next = trunc_reg;
        bufid_next = bufid_reg;
        wr_next    = 1'b0;
        done_next  = 1'b0;
        word_next  = 6'd0;
        dat_next   = 16'h0000;
        latch_desc = 1'b0;
        drop_evt   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (evt_valid_i && evt_ready_reg) begin
                    latch_desc = 1'b1;
                    if (full_count < BUF_LIMIT) begin
                        // Word 0 is constant, so it goes out on the accept edge itself.
                        state_next = HEADER;
                        bufid_next = wr_ptr;
                        wr_next    = 1'b1;
                        dat_next   = EVT_MAGIC;
                        idx_next   = 6'd1;
                        count_next = 8'd0;
                        trunc_next = 1'b0;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            HEADER: begin
                wr_next   = 1'b1;
                word_next = idx_reg;
                dat_next  = hdr_word;
                idx_next  = idx_reg + 6'd1;
                if (idx_reg == PAYLOAD_FIRST - 6'd1) state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (pay_accept) begin
                    wr_next    = 1'b1;
                    word_next  = idx_reg;
                    dat_next   = pay_dat_i;
                    idx_next   = idx_reg + 6'd1;
                    count_next = sat_inc8(count_reg);
                    if (pay_last_i) begin
                        state_next = PAD;
                    end else if (idx_reg == PAYLOAD_LAST) begin
                        trunc_next = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (pay_accept) begin
                    count_next = sat_inc8(count_reg);
                    if (pay_last_i) state_next = PAD;
                end
            end
            PAD: begin
                wr_next   = 1'b1;
                word_next = idx_reg;
                idx_next  = idx_reg + 6'd1;
                if (idx_reg == LEN_WORD) begin
                    dat_next = {trunc_reg, 7'b0, count_reg};
                end else if (idx_reg == TRAILER_WORD) begin
                    dat_next   = trailer_word;
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                word_next  = TRAILER_WORD;
                state_next = IDLE;
            end
            DROP: begin
                if (pay_accept && pay_last_i) begin
                    drop_evt   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef EVENT_WRITER_CHECKSUM_EN
    logic [15:0] csum_reg;

    // Running sum tracks the write stream, so it is complete when word 63 is formed.
    always_ff @(posedge clk33_i) begin
        if (!rst_n_i) begin
            csum_reg <= 16'h0000;
        end else if (wr_next) begin
            csum_reg <= (word_next == 6'd0) ? dat_next : csum_reg + dat_next;
        end
    end

    assign trailer_word = csum_reg;
`else
    assign trailer_word = 16'h0000;
`endif

    always_ff @(posedge clk33_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            idx_reg       <= 6'd0;
            count_reg     <= 8'd0;
            trunc_reg     <= 1'b0;
            bufid_reg     <= 2'd0;
            num_reg       <= 32'd0;
            time_reg      <= 32'd0;
            pat_reg       <= 16'd0;
            evt_ready_reg <= 1'b0;
            pay_ready_reg <= 1'b0;
            wr_reg        <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            addr_reg      <= 8'd0;
            dat_reg       <= 16'd0;
            dropped_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            trunc_reg <= trunc_next;
            bufid_reg <= bufid_next;
            if (latch_desc) begin
                num_reg  <= evt_number_i;
                time_reg <= evt_time_i;
                pat_reg  <= evt_pattern_i;
            end
            // Ready stays low through the done cycle so the tracker settles before the next accept.
            evt_ready_reg <= (state_next == IDLE) && (state_reg != DONE);
            pay_ready_reg <= state_next inside {PAYLOAD, DISCARD, DROP};
            busy_reg      <= state_next != IDLE;
            wr_reg        <= wr_next;
            done_reg      <= done_next;
            addr_reg      <= (wr_next || done_next) ? {bufid_next, word_next} : 8'd0;
            dat_reg       <= dat_next;
            if (drop_evt && dropped_reg != 16'hFFFF) dropped_reg <= dropped_reg + 16'd1;
        end
    end

    assign evt_ready_o     = evt_ready_reg;
    assign pay_ready_o     = pay_ready_reg;
    assign event_wr_o      = wr_reg;
    assign event_wr_addr_o = addr_reg;
    assign event_wr_dat_o  = dat_reg;
    assign event_done_o    = done_reg;
    assign busy_o          = busy_reg;
    assign full_count_o    = full_count;
    assign dropped_count_o = dropped_reg;

endmodule

// File: tb/tb_anita3_event_writer.sv
// Scoreboard bench for anita3_event_writer: expected record words queued at stimulus time.
module tb_anita3_event_writer;

    logic        clk33_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        evt_valid_i = 1'b0;
    logic        evt_ready_o;
    logic [31:0] evt_number_i = '0;
    logic [31:0] evt_time_i = '0;
    logic [15:0] evt_pattern_i = '0;
    logic [15:0] pay_dat_i = '0;
    logic        pay_valid_i = 1'b0;
    logic        pay_last_i = 1'b0;
    logic        pay_ready_o;
    logic        clear_evt_i = 1'b0;
    logic [7:0]  event_wr_addr_o;
    logic [15:0] event_wr_dat_o;
    logic        event_wr_o;
    logic        event_done_o;
    logic [1:0]  full_count_o;
    logic [15:0] dropped_count_o;
    logic        busy_o;

    always #15 clk33_i = ~clk33_i;

    anita3_event_writer dut (
        .clk33_i         (clk33_i),
        .rst_n_i         (rst_n_i),
        .evt_valid_i     (evt_valid_i),
        .evt_ready_o     (evt_ready_o),
        .evt_number_i    (evt_number_i),
        .evt_time_i      (evt_time_i),
        .evt_pattern_i   (evt_pattern_i),
        .pay_dat_i       (pay_dat_i),
        .pay_valid_i     (pay_valid_i),
        .pay_last_i      (pay_last_i),
        .pay_ready_o     (pay_ready_o),
        .clear_evt_i     (clear_evt_i),
        .event_wr_addr_o (event_wr_addr_o),
        .event_wr_dat_o  (event_wr_dat_o),
        .event_wr_o      (event_wr_o),
        .event_done_o    (event_done_o),
        .full_count_o    (full_count_o),
        .dropped_count_o (dropped_count_o),
        .busy_o          (busy_o)
    );

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_wr[$];
    logic [7:0]  exp_done[$];
    int          model_full = 0;
    int          model_dropped = 0;
    logic [1:0]  model_ptr = 2'd0;

    always @(negedge clk33_i) begin : monitor
        logic [23:0] ew;
        logic [7:0]  ed;
        if (event_wr_o === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%02h dat=%04h, required no write",
                         event_wr_addr_o, event_wr_dat_o);
            end else begin
                ew = exp_wr.pop_front();
                if ({event_wr_addr_o, event_wr_dat_o} !== ew) begin
                    errors++;
                    $display("FAIL write_word: got addr=%02h dat=%04h, required addr=%02h dat=%04h",
                             event_wr_addr_o, event_wr_dat_o, ew[23:16], ew[15:0]);
                end
            end
        end
        if (event_done_o === 1'b1) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got addr=%02h, required no done", event_wr_addr_o);
            end else begin
                ed = exp_done.pop_front();
                if ({event_wr_o, event_wr_addr_o} !== {1'b0, ed}) begin
                    errors++;
                    $display("FAIL done_addr: got wr=%0b addr=%02h, required wr=0 addr=%02h",
                             event_wr_o, event_wr_addr_o, ed);
                end else begin
                    $display("record done: buffer %0d addr %02h", ed[7:6], ed);
                end
            end
        end
    end

    function automatic logic [15:0] pay_word(input logic [15:0] base, input logic [15:0] step, input int i);
        return base + step * 16'(i);
    endfunction

    task automatic push_record(input logic [31:0] num, input logic [31:0] tim, input logic [15:0] pat,
                               input int n, input logic [15:0] base, input logic [15:0] step);
        logic [15:0] w[64];
        logic [15:0] sum;
        int          cnt;
        w[0] = 16'hA3E7;
        w[1] = num[31:16];
        w[2] = num[15:0];
        w[3] = tim[31:16];
        w[4] = tim[15:0];
        w[5] = pat;
        for (int i = 6; i < 62; i++) w[i] = (i - 6 < n) ? pay_word(base, step, i - 6) : 16'h0000;
        cnt = (n > 255) ? 255 : n;
        w[62] = {(n > 56) ? 1'b1 : 1'b0, 7'b0, 8'(cnt)};
        sum = 16'h0000;
        for (int i = 0; i < 63; i++) sum = sum + w[i];
`ifdef EVENT_WRITER_CHECKSUM_EN
        w[63] = sum;
`else
        w[63] = 16'h0000;
`endif
        for (int i = 0; i < 64; i++) exp_wr.push_back({model_ptr, 6'(i), w[i]});
        exp_done.push_back({model_ptr, 6'd63});
        model_ptr  = (model_ptr == 2'd1) ? 2'd0 : 2'd1;
        model_full = model_full + 1;
    endtask

    task automatic drive_desc(input logic [31:0] num, input logic [31:0] tim, input logic [15:0] pat);
        int guard = 0;
        @(negedge clk33_i);
        while (evt_ready_o !== 1'b1 && guard < 300) begin
            @(negedge clk33_i);
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL evt_ready_timeout: got ready=%b after %0d cycles, required 1", evt_ready_o, guard);
        end
        evt_valid_i   = 1'b1;
        evt_number_i  = num;
        evt_time_i    = tim;
        evt_pattern_i = pat;
        @(posedge clk33_i);
        @(negedge clk33_i);
        evt_valid_i = 1'b0;
    endtask

    task automatic drive_payload(input int n, input logic [15:0] base, input logic [15:0] step, input int stop_at);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            @(negedge clk33_i);
            while (pay_ready_o !== 1'b1 && guard < 100) begin
                @(negedge clk33_i);
                guard++;
            end
            if (guard >= 100) begin
                checks++;
                errors++;
                $display("FAIL pay_ready_timeout: got ready=%b at word %0d, required 1", pay_ready_o, i);
            end
            pay_dat_i   = pay_word(base, step, i);
            pay_valid_i = 1'b1;
            pay_last_i  = (i == n - 1);
            if (i + 1 == stop_at) rst_n_i = 1'b0;
            @(posedge clk33_i);
            if (i + 1 == stop_at) break;
        end
        @(negedge clk33_i);
        pay_valid_i = 1'b0;
        pay_last_i  = 1'b0;
    endtask

    task automatic send_event(input logic [31:0] num, input logic [31:0] tim, input logic [15:0] pat,
                              input int n, input logic [15:0] base, input logic [15:0] step);
        if (model_full < 2) begin
            push_record(num, tim, pat, n, base, step);
            $display("event %08h: %0d payload words queued", num, n);
        end else begin
            model_dropped = model_dropped + 1;
            $display("event %08h: expected drop", num);
        end
        drive_desc(num, tim, pat);
        drive_payload(n, base, step, 0);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && g < 500) begin
            @(negedge clk33_i);
            g++;
        end
        checks++;
        if (g >= 500) begin
            errors++;
            $display("FAIL drain_timeout: got %0d writes %0d dones pending, required 0",
                     exp_wr.size(), exp_done.size());
        end
        repeat (2) @(negedge clk33_i);
    endtask

    task automatic apply_reset();
        @(negedge clk33_i);
        rst_n_i     = 1'b0;
        evt_valid_i = 1'b0;
        pay_valid_i = 1'b0;
        pay_last_i  = 1'b0;
        clear_evt_i = 1'b0;
        repeat (2) @(negedge clk33_i);
        exp_wr.delete();
        exp_done.delete();
        model_full    = 0;
        model_dropped = 0;
        model_ptr     = 2'd0;
        rst_n_i = 1'b1;
        @(negedge clk33_i);
    endtask

    task automatic check_full(input string name);
        checks++;
        if (full_count_o !== 2'(model_full)) begin
            errors++;
            $display("FAIL %s: got full_count=%0d, required %0d", name, full_count_o, model_full);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk33_i);
        checks++;
        if ({evt_ready_o, pay_ready_o, event_wr_o, event_done_o, busy_o, full_count_o,
             dropped_count_o, event_wr_addr_o, event_wr_dat_o} !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b prdy=%b wr=%b done=%b busy=%b full=%0d drop=%0d, required all 0",
                     evt_ready_o, pay_ready_o, event_wr_o, event_done_o, busy_o, full_count_o, dropped_count_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk33_i);
        checks++;
        if (evt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", evt_ready_o);
        end
        check_full("reset_full");
        checks++;
        if (dropped_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_dropped: got %0d, required 0", dropped_count_o);
        end
    endtask

    task automatic test_basic_record();
        push_record(32'h00010002, 32'h12345678, 16'h00FF, 3, 16'hAAAA, 16'h1111);
        drive_desc(32'h00010002, 32'h12345678, 16'h00FF);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_record: got %b, required 1", busy_o);
        end
        drive_payload(3, 16'hAAAA, 16'h1111, 0);
        wait_drain();
        check_full("basic_full");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_event(32'h00000010, 32'h00000100, 16'h0001, 3, 16'h1000, 16'h0001);
        send_event(32'h00000011, 32'h00000200, 16'h0002, 5, 16'h2000, 16'h0101);
        wait_drain();
        check_full("b2b_full_two");
        send_event(32'h00000012, 32'h00000300, 16'h0003, 2, 16'h3000, 16'h0001);
        wait_drain();
        checks++;
        if (dropped_count_o !== 16'(model_dropped)) begin
            errors++;
            $display("FAIL drop_count: got %0d, required %0d", dropped_count_o, model_dropped);
        end
        check_full("drop_full_kept");
    endtask

    task automatic test_truncate();
        apply_reset();
        send_event(32'hCAFE0003, 32'h0BADF00D, 16'h8001, 60, 16'h0100, 16'h0003);
        wait_drain();
        check_full("trunc_full");
    endtask

    task automatic test_clear();
        int g = 0;
        apply_reset();
        @(negedge clk33_i);
        clear_evt_i = 1'b1;
        @(posedge clk33_i);
        @(negedge clk33_i);
        clear_evt_i = 1'b0;
        check_full("clear_at_zero");
        send_event(32'h00000020, 32'h00000400, 16'h0010, 2, 16'h5A5A, 16'h0011);
        wait_drain();
        check_full("clear_one_record");
        send_event(32'h00000021, 32'h00000500, 16'h0020, 2, 16'hA5A5, 16'h0022);
        while (event_done_o !== 1'b1 && g < 200) begin
            @(negedge clk33_i);
            g++;
        end
        checks++;
        if (g >= 200) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", g);
        end
        clear_evt_i = 1'b1;
        @(posedge clk33_i);
        @(negedge clk33_i);
        clear_evt_i = 1'b0;
        model_full = model_full - 1;
        check_full("clear_with_done");
        @(negedge clk33_i);
        clear_evt_i = 1'b1;
        @(posedge clk33_i);
        @(negedge clk33_i);
        clear_evt_i = 1'b0;
        model_full = model_full - 1;
        check_full("clear_plain");
        wait_drain();
    endtask

    task automatic test_reset_mid_record();
        apply_reset();
        push_record(32'h00000030, 32'h00000600, 16'h0030, 20, 16'h7000, 16'h0007);
        drive_desc(32'h00000030, 32'h00000600, 16'h0030);
        drive_payload(20, 16'h7000, 16'h0007, 10);
        checks++;
        if ({evt_ready_o, pay_ready_o, event_wr_o, event_done_o, busy_o, full_count_o,
             dropped_count_o, event_wr_addr_o, event_wr_dat_o} !== 47'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b prdy=%b wr=%b done=%b busy=%b addr=%02h, required all 0",
                     evt_ready_o, pay_ready_o, event_wr_o, event_done_o, busy_o, event_wr_addr_o);
        end
        checks++;
        if (exp_wr.size() != 49 || exp_done.size() != 1) begin
            errors++;
            $display("FAIL midreset_pending: got %0d writes %0d dones left, required 49 and 1",
                     exp_wr.size(), exp_done.size());
        end
        exp_wr.delete();
        exp_done.delete();
        model_full = 0;
        model_ptr  = 2'd0;
        rst_n_i = 1'b1;
        @(negedge clk33_i);
        send_event(32'h00000031, 32'h00000700, 16'h0031, 4, 16'h0F0F, 16'h1010);
        wait_drain();
        check_full("midreset_next_full");
    endtask

    initial begin
        test_reset();
        test_basic_record();
        test_back_to_back();
        test_truncate();
        test_clear();
        test_reset_mid_record();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
